// File: rtl/queue_drain_ctrl_if.sv
// Signal bundle between the byte-queue drain controller and its neighbours.
// Port names keep the queue/next-stage naming so wiring reads like the system diagram.
interface queue_drain_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int CNT_W  = 16
);
    logic              enable_in;
    logic [LEN_W-1:0]  len_in;
    logic [DATA_W-1:0] data_in;
    logic              dequeue_out;
    logic [DATA_W-1:0] data_out;
    logic              data_valid_out;
    logic              ready_in;
    logic              busy_out;
    logic [CNT_W-1:0]  pop_count_out;

    // The controller itself.
    modport master (
        input  enable_in,
        input  len_in,
        input  data_in,
        input  ready_in,
        output dequeue_out,
        output data_out,
        output data_valid_out,
        output busy_out,
        output pop_count_out
    );

    // The surrounding queue / next stage / testbench.
    modport slave (
        output enable_in,
        output len_in,
        output data_in,
        output ready_in,
        input  dequeue_out,
        input  data_out,
        input  data_valid_out,
        input  busy_out,
        input  pop_count_out
    );
endinterface

// File: rtl/queue_drain_ctrl.sv
// Paced consumer for the 8-entry byte queue: pops one byte, holds it on a
// valid/ready output, then waits PACE_CYCLES idle cycles before the next pop.
module queue_drain_ctrl #(
    parameter int DATA_W      = 8,
    parameter int LEN_W       = 4,
    parameter int PACE_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic                clock10mhz,
    input  logic                reset,
    queue_drain_ctrl_if.master  bus
);
    localparam int GAP_W = 4;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(PACE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        HOLD = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              deq_q, deq_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    always_ff @(posedge clock10mhz) begin
        if (reset) begin
            state_q <= IDLE;
            deq_q   <= 1'b0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            deq_q   <= deq_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        deq_d   = 1'b0;
        data_d  = data_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;

        case (state_q)
            IDLE: begin
                if (bus.enable_in && (bus.len_in != '0)) begin
                    state_d = POP;
                    deq_d   = 1'b1;
                end
            end
            POP: begin
                // The queue drops its head on this same edge, so capture it now.
                data_d  = bus.data_in;
                vld_d   = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.ready_in) begin
                    vld_d   = 1'b0;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.dequeue_out    = deq_q;
    assign bus.data_out       = data_q;
    assign bus.data_valid_out = vld_q;
    assign bus.busy_out       = busy_q;
    assign bus.pop_count_out  = cnt_q;
endmodule

// File: tb/tb_queue_drain_ctrl.sv
// Bench for queue_drain_ctrl: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a transaction-level model with a real byte queue.
module tb_queue_drain_ctrl;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;
    localparam int PACE   = 4;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic rst;
    always #50 clk = ~clk;

    queue_drain_ctrl_if #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    queue_drain_ctrl #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .PACE_CYCLES(PACE), .CNT_W(CNT_W)
    ) dut (
        .clock10mhz (clk),
        .reset      (rst),
        .bus        (bus)
    );

    int errs   = 0;
    int checks = 0;

    // Model state: what the consumer is doing, in terms of observable behaviour.
    bit              m_deq;
    bit              m_vld;
    logic [7:0]      m_data;
    int              m_cool;
    int              m_cnt;
    int              pops;
    int              cyc_n = 0;
    logic [7:0]      fifo[$];
    logic            en;
    logic            rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic drive();
        bus.enable_in = en;
        bus.ready_in  = rdy;
        bus.len_in    = LEN_W'(fifo.size());
        bus.data_in   = (fifo.size() != 0) ? fifo[0] : 8'($urandom);
    endtask

    task automatic model_edge();
        logic [7:0] head;
        logic       nonempty;
        bit         was_deq;
        head     = bus.data_in;
        nonempty = (bus.len_in != 0);
        was_deq  = m_deq;
        if (rst) begin
            m_deq = 0; m_vld = 0; m_data = 8'h00; m_cool = 0; m_cnt = 0; pops = 0;
        end else if (m_deq) begin
            m_deq  = 0;
            m_vld  = 1;
            m_data = head;
            m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            pops++;
        end else if (m_vld) begin
            if (rdy) begin
                m_vld  = 0;
                m_cool = PACE;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (en && nonempty) begin
            m_deq = 1;
        end
        // The queue sees the pulse that was high before this edge.
        if (was_deq && fifo.size() != 0) void'(fifo.pop_front());
    endtask

    task automatic cycle();
        drive();
        @(posedge clk);
        model_edge();
        cyc_n++;
        @(negedge clk);
        chk("dequeue", bus.dequeue_out, m_deq);
        chk("valid", bus.data_valid_out, m_vld);
        chk("data", bus.data_out, m_data);
        chk("busy", bus.busy_out, (m_deq || m_vld || m_cool > 0));
        chk("count", bus.pop_count_out, m_cnt);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.data_valid_out && n < 40) begin
            cycle();
            n++;
        end
        if (!bus.data_valid_out) chk(tag, 0, 1);
    endtask

    initial begin
        int rise_t[$];
        logic [7:0] got[$];
        bit prev_deq, prev_vld, seen15;
        int n;

        rst = 1'b1; en = 1'b1; rdy = 1'b1;
        m_deq = 0; m_vld = 0; m_data = 0; m_cool = 0; m_cnt = 0; pops = 0;
        @(negedge clk);

        // Reset, then an empty queue with enable high: nothing may happen.
        cycle(); cycle();
        chk("t1_reset_data", bus.data_out, 8'h00);
        rst = 1'b0;
        repeat (20) cycle();
        chk("t1_idle_busy", bus.busy_out, 0);
        chk("t1_idle_count", bus.pop_count_out, 0);

        // Single byte with ready high.
        fifo.push_back(8'hA5);
        n = 0;
        while (!bus.dequeue_out && n < 10) begin cycle(); n++; end
        chk("t2_deq_seen", bus.dequeue_out, 1);
        cycle();
        chk("t2_data", bus.data_out, 8'hA5);
        chk("t2_valid", bus.data_valid_out, 1);
        chk("t2_deq_1cyc", bus.dequeue_out, 0);
        chk("t2_count", bus.pop_count_out, 1);
        repeat (10) cycle();

        // Three bytes back to back: order and pop spacing.
        fifo.push_back(8'h11); fifo.push_back(8'h22); fifo.push_back(8'h33);
        prev_deq = 0; prev_vld = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (bus.dequeue_out && !prev_deq) rise_t.push_back(cyc_n);
            if (bus.data_valid_out && !prev_vld) got.push_back(bus.data_out);
            prev_deq = bus.dequeue_out;
            prev_vld = bus.data_valid_out;
        end
        chk("t3_npops", rise_t.size(), 3);
        chk("t3_nbytes", got.size(), 3);
        if (got.size() == 3) begin
            chk("t3_byte0", got[0], 8'h11);
            chk("t3_byte1", got[1], 8'h22);
            chk("t3_byte2", got[2], 8'h33);
        end
        if (rise_t.size() == 3) begin
            chk("t3_space01", rise_t[1] - rise_t[0], 3 + PACE);
            chk("t3_space12", rise_t[2] - rise_t[1], 3 + PACE);
        end

        // Backpressure in HOLD.
        rdy = 1'b0;
        fifo.push_back(8'h5C); fifo.push_back(8'h77);
        wait_valid("t4_timeout");
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t4_hold_data", bus.data_out, 8'h5C);
            chk("t4_hold_valid", bus.data_valid_out, 1);
            chk("t4_no_deq", bus.dequeue_out, 0);
        end
        rdy = 1'b1;
        cycle();
        chk("t4_valid_drop", bus.data_valid_out, 0);

        // Reset while holding a byte.
        rdy = 1'b0;
        wait_valid("t5_timeout");
        chk("t5_held", bus.data_out, 8'h77);
        rst = 1'b1;
        cycle();
        chk("t5_valid", bus.data_valid_out, 0);
        chk("t5_data", bus.data_out, 8'h00);
        chk("t5_busy", bus.busy_out, 0);
        chk("t5_count", bus.pop_count_out, 0);
        rst = 1'b0; rdy = 1'b1;

        // Counter wrap (CNT_W = 4 in this bench).
        seen15 = 0;
        n = 0;
        while (pops < 16 && n < 400) begin
            if (fifo.size() < 2) fifo.push_back(8'($urandom));
            cycle();
            n++;
            if (pops == 15 && !seen15) begin
                chk("t6_count15", bus.pop_count_out, 15);
                seen15 = 1;
            end
        end
        chk("t6_reached16", (pops == 16), 1);
        chk("t6_wrap", bus.pop_count_out, 0);

        // Randomized traffic, including enable drops and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 199) == 0);
            if (fifo.size() < 8 && $urandom_range(0, 2) == 0) fifo.push_back(8'($urandom));
            cycle();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
